// File: rtl/serial_chunk_adder_pkg.sv
// Shared ALU definitions: status-word bit positions, operation encodings,
// FSM state encoding and carry/operand helpers for the serial chunk adder.
package serial_chunk_adder_pkg;

  localparam int ST_CARRY    = 0;
  localparam int ST_ZERO     = 1;
  localparam int ST_NEG      = 2;
  localparam int ST_OVERFLOW = 3;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ADC = 2'b10;
  localparam logic [1:0] MODE_SBC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // SBC takes carryIn as not-borrow, so ADC and SBC both pass it through.
  function automatic logic init_carry(input logic [1:0] mode, input logic cin);
    logic c;
    case (mode)
      MODE_ADD: c = 1'b0;
      MODE_SUB: c = 1'b1;
      MODE_ADC: c = cin;
      MODE_SBC: c = cin;
      default:  c = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic is_subtract(input logic [1:0] mode);
    return (mode == MODE_SUB) || (mode == MODE_SBC);
  endfunction

endpackage

// File: rtl/serial_chunk_adder_cell.sv
// Combinational CHUNK-bit adder slice with carry in/out; the top instantiates
// one and steps it across the operand chunks.
module chunk_add_cell #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract unit: processes CHUNK bits per clock, LSB chunk
// first, and publishes result plus {V,N,Z,C} in a one-cycle done state.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             carryIn,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t             state_r, next_state_s;
  logic               accept_s, last_s;
  logic [WIDTH-1:0]   a_r, b_r, work_r, work_next_s;
  logic               carry_r, zacc_r;
  logic [CW-1:0]      cnt_r;
  int                 base_s;
  logic [CHUNK-1:0]   a_chunk_s, b_chunk_s, sum_s;
  logic               cout_s;
  logic [3:0]         status_next_s;
  logic               ready_r, busy_r, done_r;
  logic [WIDTH-1:0]   result_r;
  logic [3:0]         status_r;

  assign base_s    = int'(cnt_r) * CHUNK;
  assign a_chunk_s = a_r[base_s +: CHUNK];
  assign b_chunk_s = b_r[base_s +: CHUNK];
  assign last_s    = (cnt_r == CW'(STEPS - 1));

  chunk_add_cell #(.CHUNK(CHUNK)) u_cell (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Next state and operation acceptance; DONE can accept back-to-back.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_RUN;
          accept_s     = 1'b1;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          next_state_s = S_RUN;
          accept_s     = 1'b1;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Full-width result and flags as they stand once the current chunk lands.
  always_comb begin
    work_next_s = work_r;
    work_next_s[base_s +: CHUNK] = sum_s;
    status_next_s              = 4'b0000;
    status_next_s[ST_CARRY]    = cout_s;
    status_next_s[ST_ZERO]     = ~(zacc_r | (|sum_s));
    status_next_s[ST_NEG]      = sum_s[CHUNK-1];
    status_next_s[ST_OVERFLOW] = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                 (sum_s[CHUNK-1] != a_r[WIDTH-1]);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      work_r   <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      zacc_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      status_r <= 4'b0000;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == S_IDLE) || (next_state_s == S_DONE);
      busy_r  <= (next_state_s == S_RUN);
      done_r  <= (next_state_s == S_DONE);
      if (accept_s) begin
        a_r     <= operand1;
        b_r     <= is_subtract(mode) ? ~operand2 : operand2;
        carry_r <= init_carry(mode, carryIn);
        zacc_r  <= 1'b0;
        cnt_r   <= {CW{1'b0}};
      end else if (state_r == S_RUN) begin
        work_r  <= work_next_s;
        carry_r <= cout_s;
        zacc_r  <= zacc_r | (|sum_s);
        if (last_s) begin
          cnt_r    <= {CW{1'b0}};
          result_r <= work_next_s;
          status_r <= status_next_s;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

  assign ready     = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign statusOut = status_r;

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
- Multi-cycle, parametrised successor to the single-cycle ALU adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, with a registered carry between chunks.
- Produces the standard 4-bit ALU status word (carry, zero, negative, overflow).
- Sits in the ALU beside the combinational units and is used for wide operands where a full-width carry chain would limit clock rate.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per clock; CHUNK == WIDTH is legal (single step).
- STEPS, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- mode  in  2  00 ADD, 01 SUB, 10 ADC (add with carry-in), 11 SBC (subtract with carry-in as not-borrow).
- carryIn  in  1  carry input; used only by ADC/SBC.
- operand1  in  WIDTH  first operand; captured on accepted start.
- operand2  in  WIDTH  second operand; captured on accepted start.
- ready  out  1  high when idle, or in the done cycle.
- busy  out  1  high while chunks are being processed.
- done  out  1  one-cycle pulse when result/statusOut update.
- result  out  WIDTH  registered sum; held until the next completion.
- statusOut  out  4  {V,N,Z,C} at indices ST_OVERFLOW, ST_NEG, ST_ZERO, ST_CARRY.

Behaviour:
- Reset: state IDLE, busy=0, done=0, result=0, statusOut=0, ready=1, internal carry/chunk counter/zero accumulator cleared.
- FSM states:
  - IDLE: on start&ready, capture operand1, operand2 (inverted for SUB/SBC), mode and initial carry, then go to RUN, cnt=0.
  - Initial carry: ADD=0, SUB=1, ADC=carryIn, SBC=carryIn.
  - RUN: each cycle adds chunk cnt of both captured operands plus the carry register. It writes the sum chunk into the result shift/slot register, updates carry, ORs the chunk into the zero accumulator, and increments cnt.
  - On cnt==STEPS-1, go to DONE.
  - DONE (1 cycle): done=1 and statusOut valid. Next state is IDLE, or RUN directly if start is asserted (back-to-back accepted).
- Latency: start sampled at edge T gives busy=1 for cycles T+1..T+STEPS, and done=1 in the cycle after edge T+STEPS+... Precisely: done is high for exactly one cycle, STEPS+1 edges after the accepting edge. Throughput is one operation per STEPS+1 cycles.
- ready = (state==IDLE) | (state==DONE); busy = (state==RUN).
- start while busy is ignored; operands and mode are not re-sampled.
- Flags, computed on the final chunk:
  - C = raw carry-out of the MSB. For SUB it is 1 when there is no borrow.
  - N = result[WIDTH-1].
  - Z = (no chunk nonzero).
  - V = (op1 MSB == effective op2 MSB) && (result MSB != op1 MSB), where effective op2 is the inverted value for SUB/SBC.
- result and statusOut change only on the DONE transition. Intermediate chunks are not visible on result.
- Wrap-around: modulo 2^WIDTH, no saturation.
- rst mid-operation: abort immediately; all outputs return to reset values; no done pulse.
- rst and start in the same cycle: reset wins.

Decomposition:
- Shared ALU package/include holds:
  - ST_CARRY=0, ST_ZERO=1, ST_NEG=2, ST_OVERFLOW=3
  - MODE_ADD/SUB/ADC/SBC encodings
  - FSM state encodings
- Natural sub-module: chunk_add_cell, a combinational CHUNK-bit adder with carry in/out, instantiated once and time-multiplexed.

Test Plan (WIDTH=32, CHUNK=8 unless noted):
- ADD 0xFFFFFFFF+0x00000001 -> result 0, C=1 Z=1 N=0 V=0; done exactly 5 edges after the accepting edge, busy high 4 cycles.
- ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, V=1 N=1 C=0 Z=0; SUB 0x80000000-1 -> 0x7FFFFFFF, V=1 N=0 C=1.
- SUB 5-3 -> 0x00000002, C=1; SUB 3-5 -> 0xFFFFFFFE, C=0 N=1 Z=0; ADC 0xFF+0 with carryIn=1 -> 0x00000100, C=0.
- Start pulsed again during busy with different operands -> ignored, first result returned. Start held in the DONE cycle -> second op accepted, its done follows 5 edges later.
- rst asserted at 2nd busy cycle -> next cycle busy=0, result=0, statusOut=0, no done ever for that op; a fresh op afterwards completes correctly.
- Parameter sweep CHUNK=32 (STEPS=1) and CHUNK=4 on random operands vs reference model -> results/flags match, done latency STEPS+1.
